mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single-port, word-wide unified memory between the instruction-fetch port (IF) and the load/store port (LS).
- Arbitrates between the two requesters, with a starvation guard for IF.
- Converts LS sub-word operations (MEM_LB..MEM_SW from my_pkg) into byte strobes and formatted read data.
- Memory is synchronous: read data is valid one cycle after the access is issued.

Parameters:
- DATA_WIDTH, 32, data width; only 32 is supported.
- ADDR_WIDTH, 32, byte-address width.
- STARVE_LIMIT, 2, number of consecutive LS grants taken while IF waits before IF is forced through.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- if_req_valid  in  1  fetch request
- if_req_ready  out  1  fetch request accepted this cycle
- if_req_addr  in  ADDR_WIDTH  fetch byte address; bits [1:0] ignored
- if_rsp_valid  out  1  fetch data valid
- if_rsp_data  out  DATA_WIDTH  fetched word
- ls_req_valid  in  1  load/store request
- ls_req_ready  out  1  LS request accepted this cycle
- ls_req_op  in  3  MEM_LB..MEM_SW encoding
- ls_req_addr  in  ADDR_WIDTH  byte address
- ls_req_wdata  in  DATA_WIDTH  store data, right-aligned
- ls_rsp_valid  out  1  LS response
- ls_rsp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors
- ls_rsp_err  out  1  misaligned access
- mem_en  out  1  memory access this cycle
- mem_we  out  4  byte write strobes; 0 means read
- mem_addr  out  ADDR_WIDTH  word-aligned address ({addr[ADDR_WIDTH-1:2],2'b00})
- mem_wdata  out  DATA_WIDTH  lane-positioned write data
- mem_rdata  in  DATA_WIDTH  read data, valid the cycle after mem_en

Behaviour:
- Requester-facing outputs (if_rsp_*, ls_rsp_*) are registered. Reset value 0: rsp_valid, rsp data, err, starve_cnt.
- mem_* and *_req_ready are combinational from the current requests and starve_cnt. With no request, all are 0.
- At most one grant per cycle:
  - Only IF valid: grant IF.
  - Only LS valid: grant LS.
  - Both valid: grant LS if starve_cnt < STARVE_LIMIT, else grant IF.
- Ready depends on valid. Requesters hold valid/addr/op/wdata stable until ready.
- starve_cnt (2 bits, saturating):
  - +1 when LS is granted while if_req_valid=1.
  - Cleared to 0 when IF is granted or if_req_valid=0.
- Throughput and latency:
  - A grant can be issued every cycle (back-to-back, fully pipelined).
  - Accepted in cycle T: mem_* driven in T; the matching rsp_valid pulses for exactly one cycle in T+1.
  - Responses have no backpressure.
- The response pipeline register holds: requester id, op, addr[1:0], err.
- Store encoding:
  - SB: we=4'b0001<<addr[1:0]; wdata={4{wdata[7:0]}}.
  - SH: we = addr[1] ? 4'b1100 : 4'b0011; wdata={2{wdata[15:0]}}.
  - SW: we=4'b1111.
- Load formatting at T+1:
  - LB/LBU: byte mem_rdata[8*a+:8], with a = registered addr[1:0]; sign- or zero-extended.
  - LH/LHU: half mem_rdata[16*addr[1]+:16]; sign- or zero-extended.
  - LW: full word.
- Store response: ls_rsp_valid=1, rdata=0, err=0 at T+1.
- Misaligned LS request (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0):
  - Request is still granted (ls_req_ready=1); mem_en=0, mem_we=0 in that cycle.
  - At T+1: ls_rsp_valid=1, ls_rsp_err=1, rdata=0.
  - The slot is consumed; IF is not granted in that cycle.
- IF fetches always read (mem_we=0); if_rsp_data = mem_rdata at T+1.
- Synchronous reset mid-operation: registers clear at the sampled clock edge, so any pending response is dropped (no rsp_valid the following cycle). While rst_n=0, ready=0 and mem_en=0.

Test Plan:
- Reset: rst_n low 2 cycles with both valid -> all rsp_valid=0, mem_en=0, readies 0; after release, first grant is LS.
- LB/LBU: mem word 0x80FF7F01; LB at addr 0x103 -> ls_rsp_rdata=0xFFFFFF80 at T+1; LBU -> 0x00000080; LH at 0x102 -> 0xFFFF80FF.
- SB: SB addr 0x201, wdata 0x000000AB -> mem_we=4'b0010, mem_addr=0x200, mem_wdata=0xABABABAB; SH at 0x202 -> we=4'b1100; ls_rsp_valid at T+1.
- Misaligned: LW at 0x302 -> mem_en=0, ls_rsp_err=1, rdata=0 at T+1; SH at 0x301 -> mem_we=0, err=1.
- Arbitration/starvation: both valid continuously -> grant pattern LS, LS, IF, LS, LS, IF...; if_rsp_valid/ls_rsp_valid each 1 cycle after their grants; never both granted in one cycle.
- Back-to-back: 4 consecutive LW (IF idle) -> 4 consecutive ls_rsp_valid with correct data; reset asserted after 2nd grant -> no response for the in-flight access.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port, word-wide synchronous memory between the
// instruction-fetch port (IF) and the load/store port (LS). LS normally wins
// when both ports request. IF is forced through after STARVE_LIMIT
// consecutive LS grants taken while it waited. LS sub-word operations become
// byte strobes and lane-replicated write data. Read data is extended on the
// return path.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   if_req_*             fetch request (valid/ready handshake, byte address)
//   if_rsp_*             registered fetch response, one cycle after grant
//   ls_req_*             load/store request (op from my_pkg, address, data)
//   ls_rsp_*             registered LS response (extended data, misalign err)
//   mem_*                memory access: enable, byte strobes, word address,
//                        write data, read data (valid the cycle after mem_en)
// ---------------------------------------------------------------------------

package my_pkg;
  typedef enum logic [2:0] {
    MEM_LB  = 3'd0,
    MEM_LH  = 3'd1,
    MEM_LW  = 3'd2,
    MEM_LBU = 3'd3,
    MEM_LHU = 3'd4,
    MEM_SB  = 3'd5,
    MEM_SH  = 3'd6,
    MEM_SW  = 3'd7
  } mem_op_e;
endpackage

module mem_port_arbiter
  import my_pkg::*;
#(
  parameter int          DATA_WIDTH   = 32,
  parameter int          ADDR_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req_valid,
  output logic                  if_req_ready,
  input  logic [ADDR_WIDTH-1:0] if_req_addr,
  output logic                  if_rsp_valid,
  output logic [DATA_WIDTH-1:0] if_rsp_data,
  input  logic                  ls_req_valid,
  output logic                  ls_req_ready,
  input  logic [2:0]            ls_req_op,
  input  logic [ADDR_WIDTH-1:0] ls_req_addr,
  input  logic [DATA_WIDTH-1:0] ls_req_wdata,
  output logic                  ls_rsp_valid,
  output logic [DATA_WIDTH-1:0] ls_rsp_rdata,
  output logic                  ls_rsp_err,
  output logic                  mem_en,
  output logic [3:0]            mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);

  mem_op_e    ls_op;
  mem_op_e    rsp_op;
  logic [1:0] starve_cnt;
  logic [1:0] rsp_lane;
  logic       grant_if;
  logic       grant_ls;
  logic       ls_misaligned;
  logic       rsp_if_valid;
  logic       rsp_ls_valid;
  logic       rsp_err;
  logic [7:0] rd_byte;
  logic [15:0] rd_half;

  assign ls_op = mem_op_e'(ls_req_op);

  // Halfword accesses need an even address and word accesses need a
  // word-aligned one. Byte accesses are never misaligned.
  always_comb begin
    ls_misaligned = 1'b0;
    case (ls_op)
      MEM_LH, MEM_LHU, MEM_SH: ls_misaligned = ls_req_addr[0];
      MEM_LW, MEM_SW:          ls_misaligned = |ls_req_addr[1:0];
      default:                 ls_misaligned = 1'b0;
    endcase
  end

  // One grant per cycle. LS has priority until IF has watched STARVE_LIMIT
  // LS grants go by, then IF takes the slot. Reset blocks all grants.
  always_comb begin
    grant_ls = 1'b0;
    grant_if = 1'b0;
    if (rst_n) begin
      if (ls_req_valid && (!if_req_valid || 32'(starve_cnt) < STARVE_LIMIT)) begin
        grant_ls = 1'b1;
      end else if (if_req_valid) begin
        grant_if = 1'b1;
      end
    end
    if_req_ready = grant_if;
    ls_req_ready = grant_ls;
  end

  // A misaligned LS grant still uses the slot but never reaches the memory.
  // Sub-word store data is replicated across lanes so the strobes select it.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 4'b0000;
    mem_addr  = '0;
    mem_wdata = '0;
    if (grant_if) begin
      mem_en   = 1'b1;
      mem_addr = if_req_addr & WORD_MASK;
    end else if (grant_ls && !ls_misaligned) begin
      mem_en   = 1'b1;
      mem_addr = ls_req_addr & WORD_MASK;
      case (ls_op)
        MEM_SB: begin
          mem_we    = 4'b0001 << ls_req_addr[1:0];
          mem_wdata = {4{ls_req_wdata[7:0]}};
        end
        MEM_SH: begin
          mem_we    = ls_req_addr[1] ? 4'b1100 : 4'b0011;
          mem_wdata = {2{ls_req_wdata[15:0]}};
        end
        MEM_SW: begin
          mem_we    = 4'b1111;
          mem_wdata = ls_req_wdata;
        end
        default: begin
          mem_we    = 4'b0000;
          mem_wdata = '0;
        end
      endcase
    end
  end

  // The starvation counter counts LS grants taken while IF waits. It clears
  // as soon as IF is served or stops asking, and saturates at its maximum.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (grant_if || !if_req_valid) begin
      starve_cnt <= '0;
    end else if (grant_ls && starve_cnt != 2'b11) begin
      starve_cnt <= starve_cnt + 2'd1;
    end
  end

  // The response pipeline remembers who was granted and how to format the
  // data that memory returns next cycle. Reset drops anything in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_if_valid <= 1'b0;
      rsp_ls_valid <= 1'b0;
      rsp_op       <= MEM_LB;
      rsp_lane     <= 2'b00;
      rsp_err      <= 1'b0;
    end else begin
      rsp_if_valid <= grant_if;
      rsp_ls_valid <= grant_ls;
      if (grant_ls) begin
        rsp_op   <= ls_op;
        rsp_lane <= ls_req_addr[1:0];
        rsp_err  <= ls_misaligned;
      end
    end
  end

  // Returned data is selected from the addressed lane and extended. Data is
  // zero whenever no valid load response is being presented.
  always_comb begin
    rd_byte      = mem_rdata[{rsp_lane, 3'b000} +: 8];
    rd_half      = mem_rdata[{rsp_lane[1], 4'b0000} +: 16];
    ls_rsp_rdata = '0;
    if (rsp_ls_valid && !rsp_err) begin
      case (rsp_op)
        MEM_LB:  ls_rsp_rdata = {{24{rd_byte[7]}}, rd_byte};
        MEM_LBU: ls_rsp_rdata = {24'd0, rd_byte};
        MEM_LH:  ls_rsp_rdata = {{16{rd_half[15]}}, rd_half};
        MEM_LHU: ls_rsp_rdata = {16'd0, rd_half};
        MEM_LW:  ls_rsp_rdata = mem_rdata;
        default: ls_rsp_rdata = '0;
      endcase
    end
  end

  assign if_rsp_valid = rsp_if_valid;
  assign if_rsp_data  = rsp_if_valid ? mem_rdata : '0;
  assign ls_rsp_valid = rsp_ls_valid;
  assign ls_rsp_err   = rsp_ls_valid & rsp_err;

endmodule
